// File: rtl/mdu_ctrl.sv
// Issue/stall controller for the multiply-divide unit: launches mult/div ops,
// tracks their fixed latency, stalls dependent MDU ops and gates HI/LO writes.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic        flush,
  output logic        start,
  output logic [3:0]  mdu_op,
  output logic        hilo_we,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        issue_ok, is_mul, is_div, is_mt, is_mdu;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    issue_ok  = req_valid && !flush && reset && (state == IDLE);
    is_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU);
    is_div    = (req_op == OP_DIV)  || (req_op == OP_DIVU);
    is_mt     = (req_op == OP_MTHI) || (req_op == OP_MTLO);
    // Ops 9..15 decode as NONE and therefore never stall.
    is_mdu    = (req_op >= 4'd1) && (req_op <= 4'd8);
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    hilo_we   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (issue_ok && is_mul) begin
          start     = 1'b1;
          cnt_nxt   = MUL_CNT;
          state_nxt = MUL;
        end else if (issue_ok && is_div) begin
          start     = 1'b1;
          cnt_nxt   = DIV_CNT;
          state_nxt = DIV;
        end else if (issue_ok && is_mt) begin
          hilo_we = 1'b1;
        end
      end
      MUL, DIV: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy   = (state != IDLE);
    mdu_op = (req_valid && (state == IDLE)) ? req_op : 4'd0;
    stall  = req_valid && busy && is_mdu;
  end

  // State, latency counter and stall statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
